// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle WIDTH-bit adder/subtractor that walks the
// operands CHUNK bits per clock through one small ripple-carry slice, with
// valid/ready handshakes on the operand and result sides.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] be_r;      // b already inverted for subtract
    logic [WIDTH-1:0] res_r;     // partial result, filled LSB chunk first
    logic             carry_r;   // carry between chunks, seeded with c0
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             ovf_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [IW-1:0]    base_s;
    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK:0]   chunk_sum_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_s;
    logic             ovf_next_s;

    // Chunk slice: add the current chunk pair plus the running carry and
    // merge the chunk sum into the partial result.
    always_comb begin
        base_s      = IW'(32'(cnt_r) * CHUNK);
        a_chunk_s   = a_r[base_s +: CHUNK];
        b_chunk_s   = be_r[base_s +: CHUNK];
        chunk_sum_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
        res_next_s  = res_r;
        res_next_s[base_s +: CHUNK] = chunk_sum_s[CHUNK-1:0];
        last_s      = (cnt_r == CW'(NCH - 1));
        ovf_next_s  = (a_r[MSB] == be_r[MSB]) && (res_next_s[MSB] != a_r[MSB]);
    end

    // Next-state logic for the IDLE -> RUN -> DONE handshake sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, handshake flags and datapath registers; reset discards any
    // partial result and clears the visible result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            a_r         <= {WIDTH{1'b0}};
            be_r        <= {WIDTH{1'b0}};
            res_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            s_r         <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        be_r    <= sub ? ~b : b;
                        carry_r <= cin ^ sub;
                        res_r   <= {WIDTH{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    res_r   <= res_next_s;
                    carry_r <= chunk_sum_s[CHUNK];
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        s_r    <= res_next_s;
                        cout_r <= chunk_sum_s[CHUNK];
                        ovf_r  <= ovf_next_s;
                    end
                end
                DONE: begin
                    // result held until the consumer takes it
                end
                default: begin
                    // unreachable encodings recover through next-state logic
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign s         = s_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: a WIDTH=16/CHUNK=4 instance and a
// WIDTH=CHUNK=4 instance, checked against a plain-arithmetic model.
module tb_seq_chunk_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0;
    logic [15:0] a16 = 16'h0, b16 = 16'h0, s16;
    logic        cin16 = 1'b0, sub16 = 1'b0, cout16, ovf16;

    logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
    logic [3:0]  a4 = 4'h0, b4 = 4'h0, s4;
    logic        cin4 = 1'b0, sub4 = 1'b0, cout4, ovf4;

    int          total = 0;
    int          passed = 0;
    logic [17:0] exp16 = 18'h0;   // {ovf, cout, s} expected from the model
    logic [17:0] exp4 = 18'h0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(out_valid16),
        .out_ready(out_ready16), .s(s16), .cout(cout16), .ovf(ovf16)
    );

    seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4),
        .out_ready(out_ready4), .s(s4), .cout(cout4), .ovf(ovf4)
    );

    // Reference: whole-word two's-complement arithmetic, returns {ovf, cout, s}.
    function automatic logic [17:0] model(input int w, input logic [15:0] ma,
                                          input logic [15:0] mb, input logic mcin,
                                          input logic msub);
        longint mask, be, c0, tot, sm, am, bm, smsb;
        mask = (longint'(1) << w) - 1;
        be   = msub ? (~longint'(mb) & mask) : (longint'(mb) & mask);
        c0   = msub ? longint'(!mcin) : longint'(mcin);
        tot  = (longint'(ma) & mask) + be + c0;
        sm   = tot & mask;
        am   = (longint'(ma) >> (w - 1)) & 1;
        bm   = (be >> (w - 1)) & 1;
        smsb = (sm >> (w - 1)) & 1;
        model = {((am == bm) && (smsb != am)) ? 1'b1 : 1'b0,
                 ((tot >> w) & 1) != 0 ? 1'b1 : 1'b0,
                 16'(sm)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Every cycle a result is presented, it must match the model.
    always @(negedge clk) begin
        if (!rst && out_valid16) begin
            check("cmp16_s",    {16'h0, s16},  {16'h0, exp16[15:0]});
            check("cmp16_cout", {31'h0, cout16}, {31'h0, exp16[16]});
            check("cmp16_ovf",  {31'h0, ovf16},  {31'h0, exp16[17]});
        end
        if (!rst && out_valid4) begin
            check("cmp4_s",    {28'h0, s4},  {28'h0, exp4[3:0]});
            check("cmp4_cout", {31'h0, cout4}, {31'h0, exp4[16]});
            check("cmp4_ovf",  {31'h0, ovf4},  {31'h0, exp4[17]});
        end
    end

    // One 16-bit operation with a spurious in_valid during RUN, scrambled
    // inputs after accept, latency check, hold for `hold` cycles, then release.
    task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                        input logic tsub, input logic [15:0] ls, input logic lc,
                        input logic lo, input int hold);
        logic [17:0] m;
        int n;
        m = model(16, ta, tb, tcin, tsub);
        check("model_s",    {16'h0, m[15:0]}, {16'h0, ls});
        check("model_cout", {31'h0, m[16]},   {31'h0, lc});
        check("model_ovf",  {31'h0, m[17]},   {31'h0, lo});
        exp16 = m;
        @(negedge clk);
        a16 = ta; b16 = tb; cin16 = tcin; sub16 = tsub; in_valid16 = 1'b1;
        check("in_ready_idle", {31'h0, in_ready16}, 32'h1);
        @(posedge clk); #1;
        a16 = ~ta; b16 = ta ^ tb; cin16 = ~tcin; sub16 = ~tsub; in_valid16 = 1'b1;
        @(posedge clk); #1;
        n = 1;
        in_valid16 = 1'b0;
        check("busy_in_ready", {31'h0, in_ready16}, 32'h0);
        while (!out_valid16 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency16", n, 32'd4);
        check("s16",    {16'h0, s16},    {16'h0, ls});
        check("cout16", {31'h0, cout16}, {31'h0, lc});
        check("ovf16",  {31'h0, ovf16},  {31'h0, lo});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'h0, out_valid16}, 32'h1);
            check("hold_ready", {31'h0, in_ready16},  32'h0);
            check("hold_s",     {16'h0, s16},         {16'h0, ls});
        end
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        check("release_in_ready",  {31'h0, in_ready16},  32'h1);
        check("release_out_valid", {31'h0, out_valid16}, 32'h0);
        check("release_s_kept",    {16'h0, s16},         {16'h0, ls});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'h0, in_ready16},  32'h1);
        check("rst_out_valid", {31'h0, out_valid16}, 32'h0);
        check("rst_s",         {16'h0, s16},         32'h0);
        check("rst_cout",      {31'h0, cout16},      32'h0);
        check("rst_ovf",       {31'h0, ovf16},       32'h0);
        check("rst4_in_ready", {31'h0, in_ready4},   32'h1);
        rst = 1'b0;

        op16(16'h000B, 16'h000F, 1'b0, 1'b0, 16'h001A, 1'b0, 1'b0, 5);
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        // 5 - 7 = -2
        op16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 2);
        op16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
        op16(16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0, 0);

        // Reset at the second chunk cycle discards the operation.
        @(negedge clk);
        a16 = 16'h00FF; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready",  {31'h0, in_ready16},  32'h1);
        check("midrst_out_valid", {31'h0, out_valid16}, 32'h0);
        check("midrst_s",         {16'h0, s16},         32'h0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst_no_valid", {31'h0, out_valid16}, 32'h0);
        end

        // Single-chunk instance: 1011 + 1111 = 1_1010.
        exp4 = model(4, 16'h000B, 16'h000F, 1'b0, 1'b0);
        check("model4_s",    {16'h0, exp4[15:0]}, 32'h000A);
        check("model4_cout", {31'h0, exp4[16]},   32'h1);
        check("model4_ovf",  {31'h0, exp4[17]},   32'h0);
        @(negedge clk);
        a4 = 4'b1011; b4 = 4'b1111; cin4 = 1'b0; sub4 = 1'b0; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        check("acc4_no_valid_yet", {31'h0, out_valid4}, 32'h0);
        @(posedge clk); #1;
        check("lat4_valid", {31'h0, out_valid4}, 32'h1);
        check("s4",    {28'h0, s4},    32'hA);
        check("cout4", {31'h0, cout4}, 32'h1);
        check("ovf4",  {31'h0, ovf4},  32'h0);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        check("rel4_in_ready", {31'h0, in_ready4}, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
